// File: rtl/port_reg_bank_pkg.sv
// ---------------------------------------------------------------------------
// port_reg_bank_pkg
//   Shared definitions for the PicoBlaze port register bank: default port
//   map, channel counts, status register bit positions and an elaboration-
//   time check of a port map for range and overlap errors.
// ---------------------------------------------------------------------------
package port_reg_bank_pkg;

  // Default port map
  localparam int         DEF_NUM_WR    = 9;
  localparam int         DEF_NUM_RD    = 9;
  localparam logic [7:0] DEF_WR_BASE   = 8'h02;
  localparam logic [7:0] DEF_RD_BASE   = 8'h0D;
  localparam logic [7:0] DEF_COMMIT_ID = 8'h01;
  localparam logic [7:0] DEF_STATUS_ID = 8'h0C;

  // Supported channel count range
  localparam int MIN_CHANNELS = 1;
  localparam int MAX_CHANNELS = 16;

  // Status register bit positions
  localparam int STAT_DONE_BIT  = 0;
  localparam int STAT_BUSY_BIT  = 1;
  localparam int STAT_DIRTY_BIT = 2;

  // True when id lies inside [base, base+n-1].
  function automatic bit in_window(input int id, input int base, input int n);
    return (id >= base) && (id <= base + n - 1);
  endfunction

  // True when the port map is legal: channel counts in range, all windows
  // fit in the 8-bit port space, and no two windows/registers overlap.
  function automatic bit port_map_ok(input int wr_base, input int num_wr,
                                     input int rd_base, input int num_rd,
                                     input int commit_id, input int status_id);
    bit ok;
    ok = 1'b1;
    if (num_wr < MIN_CHANNELS || num_wr > MAX_CHANNELS) ok = 1'b0;
    if (num_rd < MIN_CHANNELS || num_rd > MAX_CHANNELS) ok = 1'b0;
    if (wr_base + num_wr - 1 > 255) ok = 1'b0;
    if (rd_base + num_rd - 1 > 255) ok = 1'b0;
    if (commit_id > 255 || status_id > 255) ok = 1'b0;
    if (!((wr_base + num_wr - 1 < rd_base) || (rd_base + num_rd - 1 < wr_base)))
      ok = 1'b0;
    if (in_window(commit_id, wr_base, num_wr) || in_window(commit_id, rd_base, num_rd))
      ok = 1'b0;
    if (in_window(status_id, wr_base, num_wr) || in_window(status_id, rd_base, num_rd))
      ok = 1'b0;
    if (commit_id == status_id) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/port_reg_bank_sticky_flag.sv
// ---------------------------------------------------------------------------
// sticky_flag
//   Single-bit event flag: set by a pulse, cleared by a read acknowledge.
//   When set and clear coincide the set wins, so no event is lost.
// Ports:
//   clk   - system clock
//   reset - synchronous active-high reset
//   set   - event pulse
//   clr   - clear request (status read)
//   flag  - current flag value
// ---------------------------------------------------------------------------
module sticky_flag (
  input  logic clk,
  input  logic reset,
  input  logic set,
  input  logic clr,
  output logic flag
);

  // NOTE: sequential state is assigned with <= only, so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset)     flag <= 1'b0;
    else if (set)  flag <= 1'b1;
    else if (clr)  flag <= 1'b0;
  end

endmodule

// File: rtl/port_reg_bank.sv
// ---------------------------------------------------------------------------
// port_reg_bank
//   PicoBlaze I/O register bank bridging to an RTC controller.
//   Write side: per-channel shadow registers collected by port writes and
//   transferred atomically to the live outputs by a commit command (or
//   discarded by an abort). Read side: a read of channel 0 snapshots all
//   input channels so a multi-byte read is coherent; a status register
//   reports dirty/busy/done with done cleared on read.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   write_strobe, port_id,
//   out_port              - PicoBlaze write bus
//   read_strobe, in_port  - PicoBlaze read strobe, registered read data
//   wr_regs, commit_pulse - committed live values, one-cycle commit marker
//   rd_regs               - input channels from the RTC side
//   done_in, busy_in      - RTC transfer-done pulse, busy level
// ---------------------------------------------------------------------------
module port_reg_bank
  import port_reg_bank_pkg::*;
#(
  parameter int         NUM_WR    = DEF_NUM_WR,
  parameter int         NUM_RD    = DEF_NUM_RD,
  parameter logic [7:0] WR_BASE   = DEF_WR_BASE,
  parameter logic [7:0] RD_BASE   = DEF_RD_BASE,
  parameter logic [7:0] COMMIT_ID = DEF_COMMIT_ID,
  parameter logic [7:0] STATUS_ID = DEF_STATUS_ID
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_strobe,
  input  logic                  read_strobe,
  input  logic [7:0]            port_id,
  input  logic [7:0]            out_port,
  output logic [7:0]            in_port,
  output logic [NUM_WR*8-1:0]   wr_regs,
  output logic                  commit_pulse,
  input  logic [NUM_RD*8-1:0]   rd_regs,
  input  logic                  done_in,
  input  logic                  busy_in
);

  // Channel 0 is read live; snap[j] holds input channel j+1.
  localparam int SNAP_N = (NUM_RD > 1) ? NUM_RD - 1 : 1;

  if (!port_map_ok(int'(WR_BASE), NUM_WR, int'(RD_BASE), NUM_RD,
                   int'(COMMIT_ID), int'(STATUS_ID))) begin : g_bad_port_map
    $fatal(1, "port_reg_bank: port map out of range or overlapping");
  end

  logic [7:0]        shadow [NUM_WR];
  logic [7:0]        live   [NUM_WR];
  logic [7:0]        snap   [SNAP_N];
  logic [NUM_WR-1:0] dirty;
  logic [NUM_WR-1:0] wr_hit;
  logic              commit_wr;
  logic              abort_wr;
  logic              snap_take;
  logic              status_rd;
  logic              done_flag;
  logic [7:0]        status;
  logic [7:0]        rd_mux;

  // -------------------------------------------------------------------------
  // Address decode
  // -------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first, so no path through
  // the block can leave it unassigned and infer a latch.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NUM_WR; i++)
      wr_hit[i] = write_strobe && (port_id == WR_BASE + 8'(i));
  end

  assign commit_wr = write_strobe && (port_id == COMMIT_ID) &&  out_port[0];
  assign abort_wr  = write_strobe && (port_id == COMMIT_ID) && !out_port[0];
  assign snap_take = read_strobe  && (port_id == RD_BASE);
  assign status_rd = read_strobe  && (port_id == STATUS_ID);

  // -------------------------------------------------------------------------
  // Write side: shadow -> live on commit, live -> shadow on abort
  // -------------------------------------------------------------------------
  // NOTE: the arrays are cleared explicitly in reset because their reset
  // value is visible (wr_regs, restored shadow); such arrays stay in flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_WR; i++) begin
        shadow[i] <= 8'h00;
        live[i]   <= 8'h00;
      end
      dirty        <= '0;
      commit_pulse <= 1'b0;
    end else begin
      commit_pulse <= commit_wr;
      if (commit_wr) begin
        for (int i = 0; i < NUM_WR; i++) live[i] <= shadow[i];
        dirty <= '0;
      end else if (abort_wr) begin
        for (int i = 0; i < NUM_WR; i++) shadow[i] <= live[i];
        dirty <= '0;
      end else begin
        for (int i = 0; i < NUM_WR; i++) begin
          if (wr_hit[i]) begin
            shadow[i] <= out_port;
            dirty[i]  <= 1'b1;
          end
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_WR; i++) begin : g_wr_pack
    assign wr_regs[8*i +: 8] = live[i];
  end

  // -------------------------------------------------------------------------
  // Read side: snapshot on channel-0 read, registered read mux
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < SNAP_N; j++) snap[j] <= 8'h00;
    end else if (snap_take) begin
      for (int j = 0; j < SNAP_N; j++)
        if (j + 1 < NUM_RD) snap[j] <= rd_regs[8*(j+1) +: 8];
    end
  end

  sticky_flag u_done_flag (
    .clk   (clk),
    .reset (reset),
    .set   (done_in),
    .clr   (status_rd),
    .flag  (done_flag)
  );

  always_comb begin
    status                 = 8'h00;
    status[STAT_DONE_BIT]  = done_flag;
    status[STAT_BUSY_BIT]  = busy_in;
    status[STAT_DIRTY_BIT] = |dirty;
  end

  // Windows are disjoint, so at most one branch matches.
  always_comb begin
    rd_mux = 8'h00;
    if (port_id == STATUS_ID) rd_mux = status;
    if (port_id == RD_BASE)   rd_mux = rd_regs[7:0];
    for (int j = 0; j < SNAP_N; j++)
      if ((j + 1 < NUM_RD) && (port_id == RD_BASE + 8'(j + 1))) rd_mux = snap[j];
  end

  always_ff @(posedge clk) begin
    if (reset) in_port <= 8'h00;
    else       in_port <= rd_mux;
  end

endmodule

// File: tb/tb_port_reg_bank.sv
// ---------------------------------------------------------------------------
// tb_port_reg_bank
//   Directed, table-driven bench for port_reg_bank with default parameters.
//   Each table row is one clock: inputs driven on the falling edge, outputs
//   compared 1 ns after the following rising edge.
// ---------------------------------------------------------------------------
module tb_port_reg_bank;

  localparam int NUM_WR = 9;
  localparam int NUM_RD = 9;

  logic                clk = 1'b0;
  logic                reset;
  logic                write_strobe;
  logic                read_strobe;
  logic [7:0]          port_id;
  logic [7:0]          out_port;
  logic [7:0]          in_port;
  logic [NUM_WR*8-1:0] wr_regs;
  logic                commit_pulse;
  logic [NUM_RD*8-1:0] rd_regs;
  logic                done_in;
  logic                busy_in;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  port_reg_bank dut (
    .clk          (clk),
    .reset        (reset),
    .write_strobe (write_strobe),
    .read_strobe  (read_strobe),
    .port_id      (port_id),
    .out_port     (out_port),
    .in_port      (in_port),
    .wr_regs      (wr_regs),
    .commit_pulse (commit_pulse),
    .rd_regs      (rd_regs),
    .done_in      (done_in),
    .busy_in      (busy_in)
  );

  typedef struct {
    logic       ws, rs, done, busy;
    logic [7:0] pid, dat, rd1;
    logic [7:0] exp_in, exp_ch0, exp_ch1, exp_ch2;
    logic       exp_pulse;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic ws, input logic rs, input logic [7:0] pid,
                              input logic [7:0] dat, input logic [7:0] rd1,
                              input logic done, input logic busy,
                              input logic [7:0] e_in, input logic [7:0] e0,
                              input logic [7:0] e1, input logic [7:0] e2,
                              input logic e_p);
    vec_t v;
    v.ws = ws; v.rs = rs; v.pid = pid; v.dat = dat; v.rd1 = rd1;
    v.done = done; v.busy = busy;
    v.exp_in = e_in; v.exp_ch0 = e0; v.exp_ch1 = e1; v.exp_ch2 = e2;
    v.exp_pulse = e_p;
    return v;
  endfunction

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic ws, input logic rs,
                       input logic [7:0] pid, input logic [7:0] dat,
                       input logic done, input logic busy);
    @(negedge clk);
    reset = rst; write_strobe = ws; read_strobe = rs;
    port_id = pid; out_port = dat; done_in = done; busy_in = busy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; write_strobe = 1'b0; read_strobe = 1'b0;
    port_id = 8'h00; out_port = 8'h00; done_in = 1'b0; busy_in = 1'b0;
    rd_regs = '0;
    for (int i = 1; i < NUM_RD; i++) rd_regs[8*i +: 8] = 8'h10 + 8'(i);
    rd_regs[7:0] = 8'hA0;

    //          ws rs pid    dat    rd1    dn bs  in     ch0    ch1    ch2    p
    vecs[0]  = mk(1, 0, 8'h02, 8'h16, 8'h59, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    vecs[1]  = mk(1, 0, 8'h03, 8'h05, 8'h59, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    vecs[2]  = mk(1, 0, 8'h04, 8'h77, 8'h59, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    vecs[3]  = mk(0, 1, 8'h0C, 8'h00, 8'h59, 0, 0, 8'h04, 8'h00, 8'h00, 8'h00, 0);
    vecs[4]  = mk(1, 0, 8'h01, 8'h01, 8'h59, 0, 0, 8'h00, 8'h16, 8'h05, 8'h77, 1);
    vecs[5]  = mk(0, 1, 8'h0C, 8'h00, 8'h59, 0, 0, 8'h00, 8'h16, 8'h05, 8'h77, 0);
    vecs[6]  = mk(1, 0, 8'h04, 8'h30, 8'h59, 0, 0, 8'h00, 8'h16, 8'h05, 8'h77, 0);
    vecs[7]  = mk(0, 1, 8'h0C, 8'h00, 8'h59, 0, 0, 8'h04, 8'h16, 8'h05, 8'h77, 0);
    vecs[8]  = mk(1, 0, 8'h01, 8'h00, 8'h59, 0, 0, 8'h00, 8'h16, 8'h05, 8'h77, 0);
    vecs[9]  = mk(0, 1, 8'h0C, 8'h00, 8'h59, 0, 0, 8'h00, 8'h16, 8'h05, 8'h77, 0);
    vecs[10] = mk(1, 0, 8'h01, 8'h01, 8'h59, 0, 0, 8'h00, 8'h16, 8'h05, 8'h77, 1);
    vecs[11] = mk(1, 0, 8'h0D, 8'hAA, 8'h59, 0, 0, 8'hA0, 8'h16, 8'h05, 8'h77, 0);
    vecs[12] = mk(1, 0, 8'h40, 8'hFF, 8'h59, 0, 0, 8'h00, 8'h16, 8'h05, 8'h77, 0);
    vecs[13] = mk(0, 1, 8'h0D, 8'h00, 8'h59, 0, 0, 8'hA0, 8'h16, 8'h05, 8'h77, 0);
    vecs[14] = mk(0, 1, 8'h0E, 8'h00, 8'h00, 0, 0, 8'h59, 8'h16, 8'h05, 8'h77, 0);
    vecs[15] = mk(0, 1, 8'h0F, 8'h00, 8'h00, 0, 0, 8'h12, 8'h16, 8'h05, 8'h77, 0);
    vecs[16] = mk(0, 0, 8'h0E, 8'h00, 8'h00, 0, 0, 8'h59, 8'h16, 8'h05, 8'h77, 0);
    vecs[17] = mk(0, 0, 8'h15, 8'h00, 8'h00, 0, 0, 8'h18, 8'h16, 8'h05, 8'h77, 0);
    vecs[18] = mk(0, 0, 8'h16, 8'h00, 8'h00, 0, 0, 8'h00, 8'h16, 8'h05, 8'h77, 0);
    vecs[19] = mk(1, 0, 8'h0B, 8'h33, 8'h00, 0, 0, 8'h00, 8'h16, 8'h05, 8'h77, 0);
    vecs[20] = mk(0, 0, 8'h0C, 8'h00, 8'h00, 0, 1, 8'h02, 8'h16, 8'h05, 8'h77, 0);
    vecs[21] = mk(0, 0, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 8'h16, 8'h05, 8'h77, 0);
    vecs[22] = mk(0, 1, 8'h0C, 8'h00, 8'h00, 0, 0, 8'h01, 8'h16, 8'h05, 8'h77, 0);
    vecs[23] = mk(0, 1, 8'h0C, 8'h00, 8'h00, 0, 0, 8'h00, 8'h16, 8'h05, 8'h77, 0);
    vecs[24] = mk(0, 1, 8'h0C, 8'h00, 8'h00, 1, 0, 8'h00, 8'h16, 8'h05, 8'h77, 0);
    vecs[25] = mk(0, 1, 8'h0C, 8'h00, 8'h00, 0, 0, 8'h01, 8'h16, 8'h05, 8'h77, 0);
    vecs[26] = mk(0, 1, 8'h0C, 8'h00, 8'h00, 0, 0, 8'h00, 8'h16, 8'h05, 8'h77, 0);

    // Reset state
    drive(1, 0, 0, 8'h0D, 8'h00, 0, 0);
    drive(1, 0, 0, 8'h0D, 8'h00, 0, 0);
    check("reset in_port", 72'(in_port), 72'h0);
    check("reset wr_regs", wr_regs, 72'h0);
    check("reset commit_pulse", 72'(commit_pulse), 72'h0);

    // Table
    for (int i = 0; i < NV; i++) begin
      rd_regs[15:8] = vecs[i].rd1;
      drive(0, vecs[i].ws, vecs[i].rs, vecs[i].pid, vecs[i].dat, vecs[i].done, vecs[i].busy);
      check($sformatf("v%0d in_port", i), 72'(in_port), 72'(vecs[i].exp_in));
      check($sformatf("v%0d ch0", i), 72'(wr_regs[7:0]), 72'(vecs[i].exp_ch0));
      check($sformatf("v%0d ch1", i), 72'(wr_regs[15:8]), 72'(vecs[i].exp_ch1));
      check($sformatf("v%0d ch2", i), 72'(wr_regs[23:16]), 72'(vecs[i].exp_ch2));
      check($sformatf("v%0d commit_pulse", i), 72'(commit_pulse), 72'(vecs[i].exp_pulse));
    end

    // Last write channel (0x0A) commit, upper channels untouched
    drive(0, 1, 0, 8'h0A, 8'hC3, 0, 0);
    drive(0, 1, 0, 8'h01, 8'h01, 0, 0);
    check("last channel commit", wr_regs, 72'hC3_00_00_00_00_00_77_05_16);

    // Reset with dirty shadow, set done flag, live snapshot and a commit
    rd_regs[15:8] = 8'h59;
    drive(0, 0, 1, 8'h0D, 8'h00, 0, 0);              // snapshot ch1 = 0x59
    drive(0, 1, 0, 8'h02, 8'h55, 0, 0);              // dirty shadow ch0
    drive(0, 0, 0, 8'h0D, 8'h00, 1, 0);              // done_flag set
    check("pre-reset in_port", 72'(in_port), 72'hA0);
    drive(1, 0, 1, 8'h0D, 8'h00, 1, 0);
    check("reset strobe in_port", 72'(in_port), 72'h0);
    check("reset strobe wr_regs", wr_regs, 72'h0);
    drive(1, 1, 0, 8'h01, 8'h01, 0, 0);
    check("reset commit wr_regs", wr_regs, 72'h0);
    check("reset commit pulse", 72'(commit_pulse), 72'h0);
    drive(0, 0, 1, 8'h0C, 8'h00, 0, 0);
    check("post-reset status", 72'(in_port), 72'h0);
    drive(0, 0, 0, 8'h0E, 8'h00, 0, 0);
    check("post-reset snap", 72'(in_port), 72'h0);
    drive(0, 0, 1, 8'h40, 8'h00, 0, 0);
    check("unmapped read 0x40", 72'(in_port), 72'h0);
    drive(0, 1, 0, 8'h01, 8'h01, 0, 0);
    check("post-reset commit wr_regs", wr_regs, 72'h0);
    check("post-reset commit pulse", 72'(commit_pulse), 72'h1);
    drive(0, 0, 0, 8'h00, 8'h00, 0, 0);
    check("pulse one cycle", 72'(commit_pulse), 72'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/port_reg_bank.md
PORT_REG_BANK -- requirements
Module: port_reg_bank

Interface
REQ-001 Parameter: NUM_WR, 9, number of 8-bit write channels (1..16).
REQ-002 Parameter: NUM_RD, 9, number of 8-bit read channels (1..16).
REQ-003 Parameter: WR_BASE, 8'h02, port_id of write channel 0; channel i at WR_BASE+i.
REQ-004 Parameter: RD_BASE, 8'h0D, port_id of read channel 0; channel i at RD_BASE+i.
REQ-005 Parameter: COMMIT_ID, 8'h01, port_id of the commit/abort command register.
REQ-006 Parameter: STATUS_ID, 8'h0C, port_id of the status register.
REQ-007 Port: clk  input  1  single system clock; all state on rising edge.
REQ-008 Port: reset  input  1  synchronous, active-high reset.
REQ-009 Port: write_strobe  input  1  PicoBlaze output strobe.
REQ-010 Port: read_strobe  input  1  PicoBlaze input strobe.
REQ-011 Port: port_id  input  8  PicoBlaze port address.
REQ-012 Port: out_port  input  8  PicoBlaze write data.
REQ-013 Port: in_port  output  8  registered read data to PicoBlaze.
REQ-014 Port: wr_regs  output  NUM_WR*8  committed live values, channel i at bits [8i+7:8i].
REQ-015 Port: commit_pulse  output  1  one-cycle pulse after each commit.
REQ-016 Port: rd_regs  input  NUM_RD*8  values from the RTC side, channel i at [8i+7:8i].
REQ-017 Port: done_in  input  1  RTC transfer-complete pulse.
REQ-018 Port: busy_in  input  1  RTC controller busy level.

Function
REQ-019 Write hit (write_strobe and port_id = WR_BASE+i, i<NUM_WR): shadow[i] <= out_port and dirty[i] <= 1; wr_regs unchanged.
REQ-020 Write to COMMIT_ID with out_port[0]=1: all wr_regs channels <= shadow in the same edge (atomic), dirty <= 0, commit_pulse = 1 for exactly the next cycle.
REQ-021 Write to COMMIT_ID with out_port[0]=0 (abort): shadow <= wr_regs, dirty <= 0, no commit_pulse.
REQ-022 Commit with dirty = 0 still updates wr_regs (no change in value) and still pulses commit_pulse.
REQ-023 in_port <= mux(port_id) every cycle, independent of read_strobe; latency one clock.
REQ-024 Read map: STATUS_ID -> {5'b0, |dirty, busy_in, done_flag}; RD_BASE -> live rd_regs[0]; RD_BASE+i (i>=1) -> snap[i]; any other address -> 8'h00.
REQ-025 Snapshot: read_strobe with port_id = RD_BASE captures all rd_regs into snap in that edge; multi-byte reads starting at channel 0 are coherent.
REQ-026 done_flag set on done_in = 1; cleared on read_strobe with port_id = STATUS_ID; simultaneous set and clear -> set wins.
REQ-027 Write to a read-only or unmapped address has no effect; read_strobe without a snapshot/status hit has no side effect.
REQ-028 Parameter ranges WR_BASE..WR_BASE+NUM_WR-1, RD_BASE..RD_BASE+NUM_RD-1, COMMIT_ID and STATUS_ID are disjoint and must not exceed 8'hFF; violation is a fatal elaboration error.

Reset
REQ-029 When reset = 1 at a clock edge: in_port, wr_regs, shadow, snap, dirty, done_flag, commit_pulse all <= 0.
REQ-030 Reset takes priority over any simultaneous strobe, commit or done_in; an uncommitted shadow write in progress is discarded.

Structure
REQ-031 Shared package holds default port IDs, channel counts and status bit positions (DONE=0, BUSY=1, DIRTY=2).
REQ-032 One sub-module, sticky_flag (set/clear-on-read flag with set priority), instantiated for done_flag; everything else is inline.

Verification
REQ-033 Write 0x16 to 0x02 and 0x05 to 0x03 -> wr_regs unchanged, status reads 0x04; write 0x01 to 0x01 -> ch0=0x16, ch1=0x05 same edge, commit_pulse high one cycle, status 0x00.
REQ-034 Write 0x30 to 0x04, then 0x00 to 0x01 -> wr_regs ch2 keeps old value, shadow restored, no commit_pulse, dirty clear.
REQ-035 rd_regs ch1=0x59, read 0x0D, change ch1 to 0x00, read 0x0E -> in_port 0x59.
REQ-036 done_in pulse, read 0x0C -> bit0=1; read again -> bit0=0; done_in coincident with status read -> bit0 stays 1.
REQ-037 Assert reset during dirty shadow and done_flag set -> all outputs 0, next status read 0x00 (busy_in=0); read of 0x40 -> 0x00.
